// File: rtl/mul_pkg.sv
// mul_pkg
// Shared definitions for the multiplier issue stage, the Booth multiplier
// and the writeback stage: FSM state encoding, default watchdog timeout,
// tag / operand / result widths and a zero-operand helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } mul_issue_state_t;

  localparam int unsigned MUL_TIMEOUT_DEFAULT = 40;
  localparam int unsigned MUL_TAG_W           = 5;
  localparam int unsigned MUL_OP_W            = 16;
  localparam int unsigned MUL_RES_W           = 32;
  localparam int unsigned MUL_WDOG_W          = 8;

  // A product with a zero operand is known without running the multiplier.
  function automatic logic is_zero_op(input logic [MUL_OP_W-1:0] a,
                                      input logic [MUL_OP_W-1:0] b);
    return (a == '0) || (b == '0);
  endfunction

endpackage

// File: rtl/mul_watchdog.sv
// mul_watchdog
// Down-counter guarding the multiplier wait. Loaded with the timeout when
// the multiplier is started, decremented on every wait cycle without a
// completion, and flags expiry in the cycle the count would reach zero.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-low reset (count cleared to 0)
//   load      in   load load_val into the counter (has priority)
//   load_val  in   W  reload value
//   dec_en    in   decrement by one this cycle
//   expired   out  this decrement takes the count from 1 to 0
module mul_watchdog
  import mul_pkg::*;
#(
  parameter int unsigned W = MUL_WDOG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec_en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Terminal-count compare on the decrementing cycle, so the owner can
  // leave its wait state on the same edge the count hits zero.
  assign expired = dec_en && !load && (count_q == W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mul_issue.sv
// mul_issue
// Issue/sequencing stage in front of the 16x16 signed Booth multiplier.
// Accepts one request at a time, pulses mul_start, waits for mul_done
// (guarded by a watchdog), then holds the 32-bit product for writeback.
//
// Optional feature macro: MUL_FASTPATH_EN
//   defined   - a request with a zero operand skips the multiplier and is
//               answered from HOLD one cycle after acceptance (result 0).
//   undefined - every request goes through ISSUE and WAIT.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_a, req_b, req_tag     signed operands and destination tag
//   mul_start                 one-cycle multiplier launch (ISSUE)
//   mul_a, mul_b              operands held for the multiplier
//   mul_result, mul_done      multiplier product and completion strobe
//   rsp_valid/rsp_ready       response handshake (valid only in HOLD)
//   rsp_result, rsp_tag       registered product and tag
//   rsp_err                   watchdog expired, result forced to 0
//   busy                      not in IDLE
//
// State table
//   state | meaning
//   IDLE  | ready for a request; operands and tag latched on accept
//   ISSUE | mul_start high; watchdog loaded
//   WAIT  | waiting for mul_done; watchdog counting down
//   HOLD  | response presented until rsp_ready
module mul_issue
  import mul_pkg::*;
#(
  parameter int unsigned TIMEOUT = MUL_TIMEOUT_DEFAULT,
  parameter int unsigned TAG_W   = MUL_TAG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [MUL_OP_W-1:0]  req_a,
  input  logic [MUL_OP_W-1:0]  req_b,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 mul_start,
  output logic [MUL_OP_W-1:0]  mul_a,
  output logic [MUL_OP_W-1:0]  mul_b,
  input  logic [MUL_RES_W-1:0] mul_result,
  input  logic                 mul_done,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MUL_RES_W-1:0] rsp_result,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam logic [MUL_WDOG_W-1:0] WDOG_LOAD = MUL_WDOG_W'(TIMEOUT);

  mul_issue_state_t state_q, state_d;

  logic [MUL_OP_W-1:0]  mul_a_q, mul_a_d;
  logic [MUL_OP_W-1:0]  mul_b_q, mul_b_d;
  logic [MUL_RES_W-1:0] rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_valid_q, rsp_valid_d;

  logic req_fire;
  logic fast_hit;
  logic wd_load;
  logic wd_dec;
  logic wd_expired;

`ifdef MUL_FASTPATH_EN
  assign fast_hit = is_zero_op(req_a, req_b);
`else
  assign fast_hit = 1'b0;
`endif

  assign req_fire = req_valid && (state_q == IDLE);

  // A completion in the same cycle as expiry must win, so the counter
  // only runs on WAIT cycles without mul_done.
  assign wd_load = (state_q == ISSUE);
  assign wd_dec  = (state_q == WAIT) && !mul_done;

  mul_watchdog #(
    .W (MUL_WDOG_W)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val (WDOG_LOAD),
    .dec_en   (wd_dec),
    .expired  (wd_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d = fast_hit ? HOLD : ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_done || wd_expired) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath logic
  always_comb begin
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          mul_a_d   = req_a;
          mul_b_d   = req_b;
          rsp_tag_d = req_tag;
          if (fast_hit) begin
            rsp_result_d = '0;
            rsp_err_d    = 1'b0;
          end
        end
      end
      WAIT: begin
        if (mul_done) begin
          rsp_result_d = mul_result;
          rsp_err_d    = 1'b0;
        end else if (wd_expired) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
        end
      end
      default: begin
      end
    endcase

    // Registered so rsp_valid rises on the same edge as the HOLD entry.
    rsp_valid_d = (state_d == HOLD);

    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    mul_start = (state_q == ISSUE);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_mul_issue.sv
// tb_mul_issue
// Self-checking bench for mul_issue. The bench plays both the execute
// stage and the multiplier; expected response timing, product, tag and
// error flag come from plain arithmetic on the request and the chosen
// multiplier latency. Honours MUL_FASTPATH_EN like the design.
module tb_mul_issue;

  localparam int TIMEOUT = 40;
  localparam int TAG_W   = 5;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [15:0]       req_a;
  logic [15:0]       req_b;
  logic [TAG_W-1:0]  req_tag;
  logic              mul_start;
  logic [15:0]       mul_a;
  logic [15:0]       mul_b;
  logic [31:0]       mul_result;
  logic              mul_done;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_result;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;
  logic              busy;

  int n_vec  = 0;
  int n_fail = 0;

  mul_issue #(
    .TIMEOUT (TIMEOUT),
    .TAG_W   (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .mul_done   (mul_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", req_ready, 1);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
  endtask

  // lat = cycles from the mul_start cycle to the mul_done pulse;
  // 0 pulses done during ISSUE only, negative never completes.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                         input logic [TAG_W-1:0] tag, input int lat, input int bp);
    int sa, sb, pa, pb;
    int exp_cyc, c, start_c, n_start, rsp_c;
    logic fast, exp_err;
    logic [31:0] exp_res;

    sa = $signed(a);
    sb = $signed(b);
    fast = 1'b0;
`ifdef MUL_FASTPATH_EN
    fast = (a == 16'h0) || (b == 16'h0);
`endif
    if (fast) begin
      exp_cyc = 1; exp_err = 1'b0; exp_res = 32'h0;
    end else if (lat >= 1 && lat <= TIMEOUT) begin
      exp_cyc = lat + 2; exp_err = 1'b0; exp_res = sa * sb;
    end else begin
      exp_cyc = TIMEOUT + 2; exp_err = 1'b1; exp_res = 32'h0;
    end

    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    step();
    c = 1;
    req_valid = 1'b0;
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    req_tag   = TAG_W'($urandom);

    start_c = -1;
    n_start = 0;
    rsp_c   = -1;
    while (c <= TIMEOUT + 10) begin
      if (rsp_valid) begin
        rsp_c = c;
        break;
      end
      if (mul_start) begin
        n_start++;
        if (start_c < 0) begin
          start_c = c;
          check("mul_a", mul_a, a);
          check("mul_b", mul_b, b);
        end
      end
      mul_done = (start_c >= 0) && (c == start_c + lat);
      pa = $signed(mul_a);
      pb = $signed(mul_b);
      mul_result = mul_done ? pa * pb : 32'hDEAD_BEEF;
      step();
      c++;
    end
    mul_done = 1'b0;

    check("rsp_cycle", rsp_c, exp_cyc);
    check("n_start", n_start, fast ? 0 : 1);

    if (rsp_c >= 0) begin
      check("rsp_result", rsp_result, exp_res);
      check("rsp_tag", rsp_tag, tag);
      check("rsp_err", rsp_err, exp_err);
      check("hold_busy", busy, 1);
      for (int i = 0; i < bp; i++) begin
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        step();
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_req_ready", req_ready, 0);
        check("bp_result", rsp_result, exp_res);
        check("bp_tag", rsp_tag, tag);
        check("bp_err", rsp_err, exp_err);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("post_req_ready", req_ready, 1);
      check("post_rsp_valid", rsp_valid, 0);
    end else begin
      rst = 1'b0;
      step();
      rst = 1'b1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_tag    = '0;
    mul_result = '0;
    mul_done   = 1'b0;
    rsp_ready  = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_vals();
    step();
    step();
    rst = 1'b1;
    step();

    // basic, extremes, fast path candidate, watchdog, expiry race, backpressure
    run_txn(16'd3, 16'hFFFC, 5'd5, 17, 0);
    run_txn(16'h8000, 16'h8000, 5'd1, 4, 1);
    run_txn(16'h7FFF, 16'h8000, 5'd2, 9, 0);
    run_txn(16'h0000, 16'h1234, 5'd7, 6, 0);
    run_txn(16'h1234, 16'h0000, 5'd8, 3, 2);
    run_txn(16'd100, 16'd200, 5'd9, -1, 0);
    run_txn(16'hFFFF, 16'hFFFF, 5'd10, TIMEOUT, 0);
    run_txn(16'd11, 16'd13, 5'd11, TIMEOUT + 1, 0);
    run_txn(16'd21, 16'd2, 5'd12, 0, 0);
    run_txn(16'h4321, 16'hABCD, 5'd31, 1, 5);

    // reset during WAIT: everything clears, late done is dropped
    req_valid = 1'b1; req_a = 16'd5; req_b = 16'd7; req_tag = 5'd3;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    check("mid_busy", busy, 1);
    rst = 1'b0;
    #1 check_reset_vals();
    step();
    rst = 1'b1;
    mul_done = 1'b1;
    mul_result = 32'd35;
    step();
    mul_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("post_rst_no_rsp", rsp_valid, 0);
      check("post_rst_idle", busy, 0);
      step();
    end
    run_txn(16'd5, 16'd7, 5'd3, 8, 0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a, b;
      int lat, sel;
      a = 16'($urandom);
      b = 16'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0: a = 16'h0;
        1: b = 16'h0;
        2: a = 16'h8000;
        3: b = 16'h7FFF;
        default: ;
      endcase
      sel = $urandom_range(0, 19);
      if (sel <= 11)      lat = $urandom_range(1, 20);
      else if (sel == 12) lat = TIMEOUT;
      else if (sel == 13) lat = TIMEOUT + 1;
      else if (sel == 14) lat = 0;
      else if (sel == 15) lat = -1;
      else                lat = $urandom_range(21, TIMEOUT - 1);
      run_txn(a, b, TAG_W'($urandom), lat, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_issue.md
# mul_issue

Issue/sequencing stage that sits directly upstream of the ALU's 16x16 signed Booth multiplier. It accepts multiply requests from the execute stage over a valid/ready handshake and launches the multiplier with a one-cycle start pulse. It waits for completion, captures the 32-bit product and presents it to writeback over a second valid/ready handshake. It also provides a zero-operand fast path and a watchdog that converts a hung multiplier into an error response.

## Interface
- TIMEOUT, 40: maximum WAIT cycles without `mul_done` before an error response; legal range 1..255.
- TAG_W, 5: width of the destination tag carried alongside each request.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  block accepts a request; high only in IDLE.
- req_a, req_b  in  16 each  signed operands.
- req_tag  in  TAG_W  destination tag.
- mul_start  out  1  single-cycle start pulse to the multiplier.
- mul_a, mul_b  out  16 each  operands to the multiplier; stable from ISSUE until `mul_done` is sampled.
- mul_result  in  32  multiplier product; valid in the cycle `mul_done` is high.
- mul_done  in  1  multiplier completion strobe.
- rsp_valid  out  1  response to writeback.
- rsp_ready  in  1  writeback accepts the response.
- rsp_result  out  32  signed product.
- rsp_tag  out  TAG_W  tag of the request.
- rsp_err  out  1  watchdog expired; `rsp_result` is 0.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - `req_valid && req_ready` latches `req_a`, `req_b` and `req_tag`.
  - Next state is ISSUE, or HOLD via the fast path.
- ISSUE: `mul_start`=1 for exactly this cycle. Watchdog loads TIMEOUT. Next state is WAIT. A `mul_done` arriving in ISSUE is ignored.
- WAIT:
  - `mul_done`=1: capture `mul_result` into `rsp_result`, set `rsp_err`=0, go to HOLD.
  - Otherwise the watchdog decrements. When it reaches 0: `rsp_result`=0, `rsp_err`=1, go to HOLD.
  - If `mul_done` arrives in the same cycle the watchdog would expire, `mul_done` wins.
- HOLD: `rsp_valid`=1, with `rsp_result`, `rsp_tag` and `rsp_err` held stable. `rsp_valid && rsp_ready` returns to IDLE.
- Arithmetic: the product is full-precision signed 16x16 to 32, with no truncation. Operands are passed to the multiplier unmodified.
- Reset values: state IDLE, so `req_ready`=1. `mul_start`=0, `mul_a`/`mul_b`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_tag`=0, `rsp_err`=0, `busy`=0, watchdog=0.
- Reset mid-operation: all state is cleared immediately. `mul_start` drops, any in-flight multiplier result is discarded, and no response is produced.

## Timing
- Request accepted in cycle T. ISSUE is at T+1, and WAIT begins at T+2.
- `mul_done` sampled high in cycle D gives `rsp_valid` from D+1.
- Watchdog expiry gives `rsp_valid` at T+2+TIMEOUT, with `rsp_err`=1.
- Response handshake in cycle H gives `req_ready`=1 at H+1. The minimum request-to-request spacing is therefore (latency + 1) cycles. There is no overlap of requests.
- `req_ready` is combinational from state. `rsp_*` outputs are registered.

## Configuration
- `MUL_FASTPATH_EN` defined: in IDLE, if `req_a`==0 or `req_b`==0, the request skips ISSUE/WAIT.
  - It goes straight to HOLD at T+1 with `rsp_result`=0 and `rsp_err`=0.
  - `mul_start` is never asserted for that request.
- Not defined: every request goes through ISSUE and WAIT, including zero operands.

## Structure
- Shared package `mul_pkg`:
  - `mul_issue_state_t` enum {IDLE, ISSUE, WAIT, HOLD}.
  - Default TIMEOUT constant.
  - Tag width constant.
  - The package is shared with the multiplier and writeback.
- One sub-module, `mul_watchdog`: an 8-bit down-counter with load, decrement-enable and `expired` output. All other logic is in `mul_issue`.

## Test plan
- Basic multiply: `req_a`=3, `req_b`=-4, tag=5; model returns `mul_done` 17 cycles after start -> `rsp_valid` at D+1 with `rsp_result`=0xFFFF_FFF4, `rsp_tag`=5, `rsp_err`=0. `mul_start` is high for exactly one cycle.
- Extremes: `req_a`=0x8000, `req_b`=0x8000 -> `rsp_result`=0x4000_0000. `req_a`=0x7FFF, `req_b`=0x8000 -> `rsp_result`=0xC000_8000.
- Fast path:
  - With `MUL_FASTPATH_EN`: `req_a`=0, `req_b`=0x1234 -> `rsp_valid` at T+1, result 0, `mul_start` never asserted.
  - Without the macro: the same request produces `mul_start` at T+1 and the response follows `mul_done`.
- Watchdog: `mul_done` held 0 with TIMEOUT=40 -> `rsp_valid` at T+42 with `rsp_err`=1 and result 0. With `mul_done` asserted exactly in the expiry cycle -> `rsp_err`=0 and result captured.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in HOLD -> `rsp_result`, `rsp_tag` and `rsp_err` stable, `req_ready`=0, a pending `req_valid` is not accepted. After `rsp_ready`, `req_ready`=1 the next cycle.
- Reset mid-WAIT: assert `rst` low for 1 cycle during WAIT -> all outputs at reset values. A later `mul_done` produces no response, and the next request completes normally.
